// File: rtl/ma_clk_cfg_seq_if.sv
// Request/response channel between the SoC CSR block and the clock configuration sequencer.
// master = requester (CSR side), slave = sequencer.
interface ma_clk_cfg_seq_if #(
  parameter int DIV_DW = 4
);
  logic              req_valid;
  logic              req_ready;
  logic [1:0]        req_op;
  logic [2:0]        req_dom;
  logic [DIV_DW-1:0] req_div;
  logic              done;
  logic              err;

  modport master (
    output req_valid, req_op, req_dom, req_div,
    input  req_ready, done, err
  );

  modport slave (
    input  req_valid, req_op, req_dom, req_div,
    output req_ready, done, err
  );
endinterface

// File: rtl/ma_clk_cfg_seq.sv
// Clock configuration sequencer: sole owner of the per-domain divider ratio, toggle,
// divider-enable and ICG-enable controls. Runs one request at a time; ratio changes
// follow ICG off -> divider off -> load ratio + toggle -> divider on -> settle -> ICG restore.
module ma_clk_cfg_seq #(
  parameter int NUM_DOM     = 5,
  parameter int DIV_DW      = 4,
  parameter int DIV_RST     = 1,
  parameter int GATE_WAIT   = 4,
  parameter int SETTLE_WAIT = 8,
  parameter int CNT_W       = 8
) (
  input  logic                      src_clk,
  input  logic                      src_rst_n,
  ma_clk_cfg_seq_if.slave           req_if,
  output logic [NUM_DOM*DIV_DW-1:0] reg_clk_div,
  output logic [NUM_DOM-1:0]        reg_clk_tog,
  output logic [NUM_DOM-1:0]        reg_clk_cken,
  output logic [NUM_DOM-1:0]        reg_icg_on
);

  // CKEN_OFF and GATE_ON name the edges that drop the divider enable (GATE_OFF exit)
  // and restore the ICG (SETTLE exit); they are never resident states and recover to IDLE.
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_GATE_OFF = 3'd1,
    ST_CKEN_OFF = 3'd2,
    ST_LOAD     = 3'd3,
    ST_CKEN_ON  = 3'd4,
    ST_SETTLE   = 3'd5,
    ST_GATE_ON  = 3'd6,
    ST_DONE     = 3'd7
  } state_t;

  localparam logic [3:0]                DOM_LIM   = 4'(NUM_DOM);
  localparam logic [CNT_W-1:0]          GATE_LD   = CNT_W'(GATE_WAIT - 1);
  localparam logic [CNT_W-1:0]          SETTLE_LD = CNT_W'(SETTLE_WAIT - 1);
  localparam logic [NUM_DOM*DIV_DW-1:0] DIV_INIT  = {NUM_DOM{DIV_DW'(DIV_RST)}};

  state_t                      state_r, state_s;
  logic [CNT_W-1:0]            cnt_r, cnt_s;
  logic [2:0]                  dom_r, dom_s;
  logic [DIV_DW-1:0]           lat_div_r, lat_div_s;
  logic                        icg_prev_r, icg_prev_s;
  logic [NUM_DOM*DIV_DW-1:0]   div_r, div_s;
  logic [NUM_DOM-1:0]          tog_r, tog_s;
  logic [NUM_DOM-1:0]          cken_r, cken_s;
  logic [NUM_DOM-1:0]          icg_r, icg_s;
  logic                        ready_r, ready_s;
  logic                        done_r, done_s;
  logic                        err_r, err_s;
  logic                        accept_s;
  logic                        bad_s;
  logic [NUM_DOM-1:0]          req_hot_s;
  logic [NUM_DOM-1:0]          dom_hot_s;

  assign accept_s = req_if.req_valid & ready_r;
  // Out-of-range domain or reserved opcode: reject without touching any control.
  assign bad_s    = ({1'b0, req_if.req_dom} >= DOM_LIM) | (req_if.req_op == 2'b11);

  // One-hot decode of the incoming and the latched domain index (all-zero when out of range).
  always_comb begin
    req_hot_s = '0;
    dom_hot_s = '0;
    for (int d = 0; d < NUM_DOM; d++) begin
      req_hot_s[d] = (req_if.req_dom == 3'(d));
      dom_hot_s[d] = (dom_r == 3'(d));
    end
  end

  // State register.
  always_ff @(posedge src_clk) begin
    if (!src_rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state decode.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          if (bad_s) begin
            state_s = ST_DONE;
          end else if (req_if.req_op == 2'b00) begin
            state_s = ST_GATE_OFF;
          end else begin
            state_s = ST_DONE;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_GATE_OFF: state_s = (cnt_r == '0) ? ST_LOAD : ST_GATE_OFF;
      ST_LOAD:     state_s = ST_CKEN_ON;
      ST_CKEN_ON:  state_s = ST_SETTLE;
      ST_SETTLE:   state_s = (cnt_r == '0) ? ST_DONE : ST_SETTLE;
      ST_DONE:     state_s = ST_IDLE;
      default:     state_s = ST_IDLE;
    endcase
  end

  // Next values of every registered output, counter and latched request.
  always_comb begin
    cnt_s      = cnt_r;
    dom_s      = dom_r;
    lat_div_s  = lat_div_r;
    icg_prev_s = icg_prev_r;
    div_s      = div_r;
    tog_s      = tog_r;
    cken_s     = cken_r;
    icg_s      = icg_r;
    err_s      = 1'b0;
    ready_s    = (state_s == ST_IDLE);
    done_s     = (state_s == ST_DONE);
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          dom_s      = req_if.req_dom;
          lat_div_s  = req_if.req_div;
          icg_prev_s = |(icg_r & req_hot_s);
          if (bad_s) begin
            err_s = 1'b1;
          end else begin
            case (req_if.req_op)
              2'b00: begin
                icg_s = icg_r & ~req_hot_s;
                cnt_s = GATE_LD;
              end
              2'b01:   icg_s = icg_r & ~req_hot_s;
              2'b10:   icg_s = icg_r | req_hot_s;
              default: icg_s = icg_r;
            endcase
          end
        end else begin
          err_s = 1'b0;
        end
      end
      ST_GATE_OFF: begin
        if (cnt_r == '0) begin
          cken_s = cken_r & ~dom_hot_s;
        end else begin
          cnt_s = cnt_r - CNT_W'(1);
        end
      end
      ST_LOAD: begin
        for (int d = 0; d < NUM_DOM; d++) begin
          div_s[d*DIV_DW +: DIV_DW] = dom_hot_s[d] ? lat_div_r : div_r[d*DIV_DW +: DIV_DW];
        end
        tog_s = tog_r ^ dom_hot_s;
      end
      ST_CKEN_ON: begin
        cken_s = cken_r | dom_hot_s;
        cnt_s  = SETTLE_LD;
      end
      ST_SETTLE: begin
        // A domain that was gated before the request stays gated afterwards.
        if (cnt_r == '0) begin
          icg_s = (icg_r & ~dom_hot_s) | (dom_hot_s & {NUM_DOM{icg_prev_r}});
        end else begin
          cnt_s = cnt_r - CNT_W'(1);
        end
      end
      ST_DONE: begin
        err_s = err_r;
      end
      default: begin
        err_s = 1'b0;
      end
    endcase
  end

  // Output, counter and request-latch registers; reset aborts any sequence in flight.
  always_ff @(posedge src_clk) begin
    if (!src_rst_n) begin
      cnt_r      <= '0;
      dom_r      <= 3'd0;
      lat_div_r  <= '0;
      icg_prev_r <= 1'b0;
      div_r      <= DIV_INIT;
      tog_r      <= '0;
      cken_r     <= '1;
      icg_r      <= '1;
      ready_r    <= 1'b1;
      done_r     <= 1'b0;
      err_r      <= 1'b0;
    end else begin
      cnt_r      <= cnt_s;
      dom_r      <= dom_s;
      lat_div_r  <= lat_div_s;
      icg_prev_r <= icg_prev_s;
      div_r      <= div_s;
      tog_r      <= tog_s;
      cken_r     <= cken_s;
      icg_r      <= icg_s;
      ready_r    <= ready_s;
      done_r     <= done_s;
      err_r      <= err_s;
    end
  end

  assign req_if.req_ready = ready_r;
  assign req_if.done      = done_r;
  assign req_if.err       = err_r;
  assign reg_clk_div      = div_r;
  assign reg_clk_tog      = tog_r;
  assign reg_clk_cken     = cken_r;
  assign reg_icg_on       = icg_r;

endmodule
